// File: rtl/feature_transform_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : feature_transform_ctrl_if
// Brief    : Control bundle between the transform sequencer and its memories.
// Revision : 1.0 - initial release
// ============================================================================
interface feature_transform_ctrl_if #(
  parameter int RA_W = 3,
  parameter int CA_W = 2
);
  logic            start;
  logic            weight_rd_en;
  logic [CA_W-1:0] weight_rd_addr;
  logic            scratchpad_load;
  logic            feature_rd_en;
  logic [RA_W-1:0] feature_rd_addr;
  logic            out_wr_en;
  logic [RA_W-1:0] out_wr_row;
  logic [CA_W-1:0] out_wr_col;
  logic            busy;
  logic            done;

  modport master (
    input  start,
    output weight_rd_en, weight_rd_addr, scratchpad_load,
    output feature_rd_en, feature_rd_addr,
    output out_wr_en, out_wr_row, out_wr_col,
    output busy, done
  );

  modport slave (
    output start,
    input  weight_rd_en, weight_rd_addr, scratchpad_load,
    input  feature_rd_en, feature_rd_addr,
    input  out_wr_en, out_wr_row, out_wr_col,
    input  busy, done
  );
endinterface
`default_nettype wire

// File: rtl/feature_transform_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : feature_transform_ctrl
// Brief    : Sequences weight-column loads and feature-row streaming for FM x WM.
// Revision : 1.0 - initial release
// ============================================================================
module feature_transform_ctrl #(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 6,
  parameter int WEIGHT_COLS  = 3,
  parameter int RA_W         = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int CA_W         = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  feature_transform_ctrl_if.master  bus
);

  localparam logic [RA_W-1:0] c_row_last = RA_W'(FEATURE_ROWS - 1);
  localparam logic [CA_W-1:0] c_col_last = CA_W'(WEIGHT_COLS - 1);

  generate
    if (FEATURE_ROWS < 1 || FEATURE_COLS < 1 || WEIGHT_COLS < 1) begin : g_bad_dims
      $error("feature_transform_ctrl: all matrix dimensions must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_RD     = 3'd1,
    S_W_LD     = 3'd2,
    S_F_STREAM = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RA_W-1:0] r_row;
  logic [RA_W-1:0] w_row_nxt;
  logic [CA_W-1:0] r_col;
  logic [CA_W-1:0] w_col_nxt;
  logic            r_wr_pend;
  logic [RA_W-1:0] r_wr_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_wr_pend <= 1'b0;
      r_wr_row  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      // Product write trails each feature read by the memory latency.
      r_wr_pend <= (r_state == S_F_STREAM);
      r_wr_row  <= (r_state == S_F_STREAM) ? r_row : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_W_RD;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      S_W_RD:  w_state_nxt = S_W_LD;
      S_W_LD:  w_state_nxt = S_F_STREAM;
      S_F_STREAM: begin
        if (r_row == c_row_last) begin
          w_row_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end
      S_DRAIN: begin
        // Column advances only after the last row's write has been issued.
        if (r_col == c_col_last) begin
          w_col_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_col_nxt   = r_col + 1'b1;
          w_state_nxt = S_W_RD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.weight_rd_en    = (r_state == S_W_RD);
  assign bus.weight_rd_addr  = (r_state == S_W_RD) ? r_col : '0;
  assign bus.scratchpad_load = (r_state == S_W_LD);
  assign bus.feature_rd_en   = (r_state == S_F_STREAM);
  assign bus.feature_rd_addr = (r_state == S_F_STREAM) ? r_row : '0;
  assign bus.out_wr_en       = r_wr_pend;
  assign bus.out_wr_row      = r_wr_row;
  assign bus.out_wr_col      = r_wr_pend ? r_col : '0;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.done            = (r_state == S_DONE);

endmodule
`default_nettype wire
